// File: rtl/shift_reg_ctrl_pkg.sv
// Shared state encoding and default geometry for the serial shift controller.
package shift_reg_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_reg_ctrl_shift_reg.sv
// Parallel-load, serial-in shift register; shifts left with the new bit entering the LSB.
module shift_reg
    import shift_reg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_ser,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load has priority over shift; both come from the controller FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[WIDTH-2:0], i_ser};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Word-serial transceiver: loads a word, shifts it out MSB first while shifting
// ser_in in, then presents the received word until the consumer takes it.
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             bit_strobe,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             abort,
    output logic             busy
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_cnt_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_cnt_nxt;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_q;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Next-state, counter and shift-register control decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_div_cnt_nxt = r_div_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !abort) begin
                    w_load        = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else if (r_div_cnt == DIV_LAST) begin
                    w_shift       = 1'b1;
                    w_div_cnt_nxt = '0;
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                // abort together with out_ready is just a return to IDLE
                if (abort || out_ready) begin
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_ser   (ser_in),
        .i_data  (data_in),
        .o_q     (w_q)
    );

    // Status and data outputs decoded from registered state.
    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state == SHIFT);
    assign out_valid  = (r_state == DONE);
    assign ser_out    = busy & w_q[WIDTH-1];
    assign bit_strobe = w_shift;
    assign par_out    = out_valid ? w_q : '0;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench: default instance (WIDTH=8, DIV=2) plus a DIV=1 instance.
module tb_shift_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic       ser_in;
    logic       ser_out;
    logic       bit_strobe;
    logic [7:0] par_out;
    logic       out_valid;
    logic       out_ready;
    logic       abort;
    logic       busy;
    logic       loopback;
    logic       ser_c;

    logic [7:0] d1_data;
    logic       d1_valid;
    logic       d1_in_ready;
    logic       d1_ser_in;
    logic       d1_ser_out;
    logic       d1_strobe;
    logic [7:0] d1_par;
    logic       d1_out_valid;
    logic       d1_out_ready;
    logic       d1_abort;
    logic       d1_busy;

    int n_cmp;
    int n_err;
    logic [7:0] sb_q[$];
    logic [7:0] sb1_q[$];

    assign ser_in    = loopback ? ser_out : ser_c;
    assign d1_ser_in = d1_ser_out;

    shift_reg_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .par_out    (par_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .abort      (abort),
        .busy       (busy)
    );

    shift_reg_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (d1_data),
        .in_valid   (d1_valid),
        .in_ready   (d1_in_ready),
        .ser_in     (d1_ser_in),
        .ser_out    (d1_ser_out),
        .bit_strobe (d1_strobe),
        .par_out    (d1_par),
        .out_valid  (d1_out_valid),
        .out_ready  (d1_out_ready),
        .abort      (d1_abort),
        .busy       (d1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   1);
        chk({tag, "_ser_out"},    32'(ser_out),    0);
        chk({tag, "_bit_strobe"}, 32'(bit_strobe), 0);
        chk({tag, "_par_out"},    32'(par_out),    0);
        chk({tag, "_out_valid"},  32'(out_valid),  0);
        chk({tag, "_busy"},       32'(busy),       0);
    endtask

    // Present a word in IDLE; returns right after the accepting edge.
    task automatic start(input logic [7:0] d, input logic lb, input logic sc, input logic push);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        data_in  = d;
        in_valid = 1'b1;
        loopback = lb;
        ser_c    = sc;
        if (push) sb_q.push_back(lb ? d : {8{sc}});
        @(posedge clk);
    endtask

    // Follow one full transfer from the accepting edge to DONE.
    task automatic stream(input logic [7:0] d);
        logic [15:0] s_obs, s_exp, o_obs, o_exp;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_shift", 32'(busy), 1);
        chk("in_ready_shift", 32'(in_ready), 0);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            s_obs[c] = bit_strobe;
            o_obs[c] = ser_out;
            s_exp[c] = (c % 2 == 1);
            o_exp[c] = d[7 - c / 2];
        end
        chk("out_valid_early", 32'(out_valid), 0);
        chk("strobe_pattern", 32'(s_obs), 32'(s_exp));
        chk("ser_out_seq", 32'(o_obs), 32'(o_exp));
        @(negedge clk);
        chk("out_valid_lat16", 32'(out_valid), 1);
        chk("in_ready_done", 32'(in_ready), 0);
        chk("ser_out_done", 32'(ser_out), 0);
    endtask

    // Pop the scoreboard against par_out and release DONE.
    task automatic consume(input logic with_abort);
        logic [7:0] e;
        chk("sb_depth", 32'(sb_q.size()), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("par_out", 32'(par_out), 32'(e));
        end
        out_ready = 1'b1;
        abort     = with_abort;
        @(negedge clk);
        out_ready = 1'b0;
        abort     = 1'b0;
        chk("in_ready_after", 32'(in_ready), 1);
        chk("out_valid_after", 32'(out_valid), 0);
    endtask

    initial begin
        int         ov_cnt;
        logic [7:0] e;
        logic [7:0] s1_obs, o1_obs, o1_exp;
        logic [7:0] f0;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; data_in = '0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        loopback = 1'b1; ser_c = 1'b0;
        d1_data = '0; d1_valid = 1'b0; d1_out_ready = 1'b0; d1_abort = 1'b0;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // loopback 0xA5
        start(8'hA5, 1'b1, 1'b0, 1'b1);
        stream(8'hA5);
        consume(1'b0);

        // constant ser_in=1 with 0x3C
        start(8'h3C, 1'b0, 1'b1, 1'b1);
        stream(8'h3C);
        consume(1'b0);

        // abort in IDLE blocks acceptance
        @(negedge clk);
        data_in = 8'h42; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_ready", 32'(in_ready), 1);
        in_valid = 1'b0; abort = 1'b0;

        // backpressure in DONE with a waiting word
        start(8'h96, 1'b1, 1'b0, 1'b1);
        stream(8'h96);
        data_in = 8'h11; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_par_stable", 32'(par_out), 32'h96);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        chk("sb_depth_bp", 32'(sb_q.size()), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("par_out_bp", 32'(par_out), 32'(e));
        end
        sb_q.push_back(8'h11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", 32'(in_ready), 1);
        @(posedge clk);
        stream(8'h11);
        consume(1'b0);

        // abort after three shifts of 0x5A
        start(8'h5A, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_ser_out", 32'(ser_out), 0);
        ov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        chk("abort_no_out_valid", 32'(ov_cnt), 0);
        start(8'hC3, 1'b1, 1'b0, 1'b1);
        stream(8'hC3);
        consume(1'b0);

        // abort and out_ready together in DONE
        start(8'hE7, 1'b1, 1'b0, 1'b1);
        stream(8'hE7);
        consume(1'b1);

        // asynchronous reset pulse mid-SHIFT
        start(8'h77, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        rst_n = 1'b1;
        data_in = 8'h01; in_valid = 1'b1; loopback = 1'b1;
        sb_q.push_back(8'h01);
        @(posedge clk);
        stream(8'h01);
        consume(1'b0);

        // DIV=1 instance, loopback 0xF0
        f0 = 8'hF0;
        @(negedge clk);
        chk("d1_in_ready", 32'(d1_in_ready), 1);
        d1_data = f0; d1_valid = 1'b1;
        sb1_q.push_back(f0);
        @(posedge clk);
        @(negedge clk);
        d1_valid = 1'b0;
        chk("d1_busy", 32'(d1_busy), 1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            s1_obs[c] = d1_strobe;
            o1_obs[c] = d1_ser_out;
            o1_exp[c] = f0[7 - c];
        end
        chk("d1_out_valid_early", 32'(d1_out_valid), 0);
        chk("d1_strobe_every", 32'(s1_obs), 32'hFF);
        chk("d1_ser_out_seq", 32'(o1_obs), 32'(o1_exp));
        @(negedge clk);
        chk("d1_out_valid_lat8", 32'(d1_out_valid), 1);
        chk("d1_sb_depth", 32'(sb1_q.size()), 1);
        if (sb1_q.size() > 0) begin
            e = sb1_q.pop_front();
            chk("d1_par_out", 32'(d1_par), 32'(e));
        end
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        chk("d1_in_ready_after", 32'(d1_in_ready), 1);

        chk("sb_empty_end", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: shift word width in bits (>=2).
REQ-002 Parameter DIV, default 2: clocks per bit period (>=1).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  data_in valid.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 ser_in  input  1  serial receive bit.
REQ-009 ser_out  output  1  serial transmit bit, MSB first.
REQ-010 bit_strobe  output  1  one-cycle pulse in each cycle where a shift occurs.
REQ-011 par_out  output  WIDTH  received word.
REQ-012 out_valid  output  1  par_out valid.
REQ-013 out_ready  input  1  consumer accepts par_out.
REQ-014 abort  input  1  synchronous cancel of the current transfer.
REQ-015 busy  output  1  high in state SHIFT.

Function
REQ-016 States IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE: in_ready=1; on in_valid&&!abort the word is loaded into the shift register, bit_cnt=0, div_cnt=0, next state SHIFT.
REQ-018 SHIFT: in_ready=0, busy=1, ser_out = shift register MSB; div_cnt counts 0..DIV-1 and wraps.
REQ-019 Shift event when div_cnt==DIV-1: register shifts left one bit, ser_in enters the LSB, bit_cnt increments, bit_strobe=1.
REQ-020 After the WIDTH-th shift event the next state is DONE; bit_cnt is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.
REQ-021 Latency: out_valid rises exactly WIDTH*DIV clock edges after the accepting edge (16 for defaults).
REQ-022 DONE: out_valid=1, par_out = shift register contents, held stable until out_ready=1; next state IDLE on out_ready.
REQ-023 in_ready=0 in DONE; a new word is never accepted while par_out is unconsumed.
REQ-024 abort in SHIFT or DONE: next state IDLE, no out_valid pulse, register contents discarded; in IDLE abort blocks acceptance for that cycle.
REQ-025 abort and out_ready together in DONE: next state IDLE, no extra effect.
REQ-026 ser_out=0 and bit_strobe=0 outside SHIFT.
REQ-027 DIV=1: a shift event occurs every SHIFT cycle.

Reset
REQ-028 rst_n low forces, without a clock edge: state IDLE, shift register 0, bit_cnt 0, div_cnt 0.
REQ-029 Output reset values: in_ready=1, ser_out=0, bit_strobe=0, par_out=0, out_valid=0, busy=0.
REQ-030 Reset asserted mid-transfer discards the transfer; first acceptance possible on the first edge after rst_n rises.

Structure
REQ-031 Package shift_reg_ctrl_pkg holds the state encoding constants (IDLE, SHIFT, DONE) and the default WIDTH/DIV values.
REQ-032 One sub-module: shift_reg, the parallel-load/serial-in WIDTH-bit shift register, driven by load and shift-enable from the FSM; counters and FSM stay in shift_reg_ctrl.

Verification
REQ-033 Loopback ser_in=ser_out, defaults, data_in=0xA5 pulsed with in_valid -> out_valid at edge 16 after accept, par_out=0xA5, 8 bit_strobe pulses every 2nd cycle.
REQ-034 ser_in=1 constant, data_in=0x3C -> ser_out bit sequence 0,0,1,1,1,1,0,0 (2 clocks each), par_out=0xFF.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1, data_in=0x11 -> par_out stable, in_ready=0, no acceptance until out_ready=1; then IDLE and 0x11 accepted next cycle.
REQ-036 abort at bit 3 of 0x5A -> IDLE next cycle, no out_valid, busy=0, following transfer 0xC3 in loopback returns 0xC3.
REQ-037 rst_n low for 1 ns mid-SHIFT (asynchronous to clk) -> all outputs at reset values immediately; transfer 0x01 after release returns 0x01 in loopback.
REQ-038 DIV=1, WIDTH=8, loopback 0xF0 -> out_valid 8 edges after accept, bit_strobe high every SHIFT cycle.
